imm_field_decoder: RTL

IMM_FIELD_DECODER -- requirements
Module: imm_field_decoder

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/op2_sel_decode.sv | 37 +++
 rtl/imm_field_decoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- RV32I opcode constants, ALU second-operand select codes and
// the decoded operand bundle shared by the decoder and ALUSrc2. rev 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [4:0] OP2_RS2     = 5'd0;
  localparam logic [4:0] OP2_IMM12   = 5'd1;
  localparam logic [4:0] OP2_STORE   = 5'd2;
  localparam logic [4:0] OP2_SHAMT   = 5'd3;
  localparam logic [4:0] OP2_IMM20   = 5'd4;
  localparam logic [4:0] OP2_JAL     = 5'd5;
  localparam logic [4:0] OP2_ILLEGAL = 5'd31;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  typedef struct packed {
    logic [4:0]  op2;
    logic [31:0] rs2;
    logic [6:0]  imm_7;
    logic [4:0]  imm_5;
    logic [11:0] imm_12;
    logic [4:0]  shamt_5;
    logic [19:0] imm_20;
    logic        illegal;
  } bundle_t;

  function automatic bundle_t pack_bundle(input logic [31:0] instr,
                                          input logic [31:0] rs2_data,
                                          input logic [4:0]  op2,
                                          input logic        illegal);
    bundle_t b;
    b.op2     = op2;
    b.rs2     = rs2_data;
    b.imm_7   = instr[31:25];
    b.imm_5   = instr[11:7];
    b.imm_12  = instr[31:20];
    b.shamt_5 = instr[24:20];
    b.imm_20  = instr[31:12];
    b.illegal = illegal;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/op2_sel_decode.sv
// op2_sel_decode -- purely combinational opcode/funct3 to ALU second-operand
// select mapping. rev 1.0
`default_nettype none

module op2_sel_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [4:0] op2,
  output logic       illegal
);

  always_comb begin
    op2     = OP2_ILLEGAL;
    illegal = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_BRANCH: op2 = OP2_RS2;
      OPC_OP_IMM: begin
        // Shifts carry shamt in the immediate field rather than a full imm12
        if (funct3 == F3_SLL || funct3 == F3_SR) op2 = OP2_SHAMT;
        else                                     op2 = OP2_IMM12;
      end
      OPC_LOAD, OPC_JALR:  op2 = OP2_IMM12;
      OPC_STORE:           op2 = OP2_STORE;
      OPC_LUI, OPC_AUIPC:  op2 = OP2_IMM20;
      OPC_JAL:             op2 = OP2_JAL;
      default: begin
        op2     = OP2_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_field_decoder.sv
// imm_field_decoder -- extracts RV32I immediate fields and the OP2 select,
// buffering decoded bundles in a two-entry valid/ready FIFO. rev 1.0
`default_nettype none

module imm_field_decoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  OP2,
  output logic [31:0] RS2,
  output logic [6:0]  Imm_7,
  output logic [4:0]  Imm_5,
  output logic [11:0] Imm_12,
  output logic [4:0]  Shamt_5,
  output logic [19:0] Imm_20,
  output logic        illegal,
  output logic [15:0] illegal_cnt
);

  fifo_state_t state, state_nxt;
  bundle_t     head, tail, new_bundle;
  logic [4:0]  dec_op2;
  logic        dec_illegal;
  logic        ready_en;
  logic        accept, emit;

  op2_sel_decode u_op2_sel_decode (
    .opcode  (instr[6:0]),
    .funct3  (instr[14:12]),
    .op2     (dec_op2),
    .illegal (dec_illegal)
  );

  assign new_bundle = pack_bundle(instr, rs2_data, dec_op2, dec_illegal);

  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready  = ready_en && (state != FIFO_FULL);
  assign out_valid = (state != FIFO_EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FIFO_EMPTY;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FIFO_EMPTY: if (accept) state_nxt = FIFO_ONE;
      FIFO_ONE: begin
        if (accept && !emit)      state_nxt = FIFO_FULL;
        else if (!accept && emit) state_nxt = FIFO_EMPTY;
      end
      FIFO_FULL:  if (emit) state_nxt = FIFO_ONE;
      default:    state_nxt = FIFO_EMPTY;
    endcase
  end

  // head always holds the oldest bundle so outputs come straight from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        FIFO_EMPTY: if (accept) head <= new_bundle;
        FIFO_ONE: begin
          if (accept && emit) head <= new_bundle;
          else if (accept)    tail <= new_bundle;
        end
        FIFO_FULL:  if (emit) head <= tail;
        default: begin
          head <= '0;
          tail <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= 16'h0000;
    end else if (accept && dec_illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'h0001;
    end
  end

  assign OP2     = head.op2;
  assign RS2     = head.rs2;
  assign Imm_7   = head.imm_7;
  assign Imm_5   = head.imm_5;
  assign Imm_12  = head.imm_12;
  assign Shamt_5 = head.shamt_5;
  assign Imm_20  = head.imm_20;
  assign illegal = head.illegal;

endmodule

`default_nettype wire
